instr_fetch_stage: RTL
======================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter PC_W, default 64, PC width in bits.
REQ-003 SHALL have parameter IMEM_AW, default 9, instruction-memory address width (depth 2^IMEM_AW words).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value after reset and after load mode.
REQ-005 SHALL have parameter NOP_INSTR, default 0, bubble instruction value.
REQ-006 SHALL have parameter CNT_W, default 16, fetch-counter width.
REQ-007 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port Instr_IN  input  INSTR_W  instruction word to load.
REQ-010 SHALL have port Instr_W_en  input  1  load-mode enable / memory write strobe.
REQ-011 SHALL have port I_W_Addr  input  IMEM_AW  memory write address.
REQ-012 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-013 SHALL have port redirect  input  1  taken branch/jump.
REQ-014 SHALL have port redirect_pc  input  PC_W  branch/jump target.
REQ-015 SHALL have port PC  output  PC_W  current fetch PC (registered).
REQ-016 SHALL have port PC_plus_one  output  PC_W  PC+1, combinational.
REQ-017 SHALL have port Instruction_ID  output  INSTR_W  IF/ID instruction register.
REQ-018 SHALL have port PC_ID  output  PC_W  PC of Instruction_ID.
REQ-019 SHALL have port valid_ID  output  1  Instruction_ID is a real fetched instruction.
REQ-020 SHALL have port fetch_count  output  CNT_W  number of valid instructions delivered to ID.

Function
REQ-021 SHALL read memory combinationally at index PC[IMEM_AW-1:0]; PC is word-addressed, step 1.
REQ-022 SHALL write Instr_IN to mem[I_W_Addr] on a rising edge when Instr_W_en=1; memory contents are not reset.
REQ-023 SHALL apply per-edge priority: rst > Instr_W_en > redirect > stall > normal fetch.
REQ-024 Load (Instr_W_en=1): PC<=RESET_PC, Instruction_ID<=NOP_INSTR, PC_ID<=0, valid_ID<=0; fetch_count held.
REQ-025 Redirect: PC<=redirect_pc, Instruction_ID<=NOP_INSTR, valid_ID<=0, PC_ID<=0 (flush, 1-cycle bubble); overrides stall.
REQ-026 Stall (no redirect/load): PC, Instruction_ID, PC_ID, valid_ID, fetch_count all held.
REQ-027 Normal: Instruction_ID<=mem[PC], PC_ID<=PC, valid_ID<=1, PC<=PC_plus_one.
REQ-028 SHALL give 1-cycle latency from PC presentation to Instruction_ID.
REQ-029 SHALL compute PC_plus_one modulo 2^PC_W (all-ones wraps to 0); memory index wraps at depth via low bits.
REQ-030 SHALL increment fetch_count on each edge where valid_ID is loaded with 1, saturating at 2^CNT_W-1.
REQ-031 First fetch after Instr_W_en falls SHALL be from RESET_PC on the next edge; no write/read collision (fetch suppressed while loading).
REQ-032 redirect_pc SHALL be used at full PC_W width; upper bits beyond IMEM_AW are retained in PC but ignored for indexing.

Reset
REQ-033 On rst=1, immediately and without clock: PC=RESET_PC, Instruction_ID=NOP_INSTR, PC_ID=0, valid_ID=0, fetch_count=0.
REQ-034 Reset asserted mid-operation (stall, redirect or load active) SHALL override all; a write coinciding with an edge during rst is not guaranteed.
REQ-035 On first edge after rst deasserts with no other control, SHALL perform a normal fetch from RESET_PC.

Verification
REQ-036 Load mem[0..3]=0x11,0x22,0x33,0x44, drop Instr_W_en, run 4 edges -> Instruction_ID 0x11..0x44, PC_ID 0..3, valid_ID=1, fetch_count=4, PC=4.
REQ-037 stall=1 for 3 edges after fetching 0x22 -> Instruction_ID=0x22, PC=2, fetch_count unchanged; release -> 0x33 next edge.
REQ-038 redirect=1, redirect_pc=3 with stall=1 simultaneously -> next edge valid_ID=0, Instruction_ID=NOP_INSTR, PC=3; following edge Instruction_ID=0x44, PC_ID=3.
REQ-039 redirect_pc=2^IMEM_AW-1, run 2 edges -> PC_ID=511 then 512, second instruction read from mem[0]; redirect_pc=all-ones -> PC_plus_one=0.
REQ-040 Assert rst asynchronously mid-run between edges -> outputs reach reset values before next edge; fetch_count=0; memory contents preserved (refetch 0x11 at PC 0).
REQ-041 CNT_W=2 build, 5 normal fetches -> fetch_count saturates at 3.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: word-addressed PC, loadable instruction memory
// and the IF/ID pipeline register with flush, stall and fetch counting.
module instr_fetch_stage #(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 64,
    parameter int unsigned        IMEM_AW   = 9,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] Instr_IN,
    input  logic               Instr_W_en,
    input  logic [IMEM_AW-1:0] I_W_Addr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    PC_plus_one,
    output logic [INSTR_W-1:0] Instruction_ID,
    output logic [PC_W-1:0]    PC_ID,
    output logic               valid_ID,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam int unsigned      DEPTH   = 1 << IMEM_AW;
    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] fetch_instr;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_id_q, pc_id_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Memory has no reset so its image survives a core reset.
    always_ff @(posedge clk) begin
        if (Instr_W_en) begin
            mem_q[I_W_Addr] <= Instr_IN;
        end
    end

    assign fetch_instr = mem_q[pc_q[IMEM_AW-1:0]];
    assign PC_plus_one = pc_q + PC_ONE;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (Instr_W_en) begin
            pc_d    = RESET_PC;
            instr_d = NOP_INSTR;
            pc_id_d = '0;
            valid_d = 1'b0;
        end else if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            pc_id_d = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = PC_plus_one;
            instr_d = fetch_instr;
            pc_id_d = pc_q;
            valid_d = 1'b1;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc_id_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC             = pc_q;
    assign Instruction_ID = instr_q;
    assign PC_ID          = pc_id_q;
    assign valid_ID       = valid_q;
    assign fetch_count    = cnt_q;

endmodule
